interval_timer: RTL
===================

Name: interval_timer

Overview:
- Programmable interval timer and timing-parameter store for the traffic light controller.
- Sits beside TrafficControllerFSM:
  - accepts its start_timer / requesting_interval request;
  - counts the selected interval in seconds from a prescaled clock;
  - returns a one-cycle expired pulse.
- Holds the three timing parameters (t_base, t_ext, t_yel), rewritable at runtime through a reprogram port.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; must be >= 2.
- VAL_W, 4: width of the stored interval values, in seconds.
- DEF_BASE, 6: t_base value after reset or restore.
- DEF_EXT, 3: t_ext value after reset or restore.
- DEF_YEL, 2: t_yel value after reset or restore.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; low at a rising edge resets the block.
- start_timer  in  1  one-cycle request to load and start the interval selected by requesting_interval.
- requesting_interval  in  2  interval select: 00 t_base, 01 t_ext, 10 t_yel, 11 treated as t_base.
- reprogram  in  1  one-cycle write strobe for a timing parameter.
- time_param_sel  in  2  write target: 00 t_base, 01 t_ext, 10 t_yel, 11 restore all defaults.
- time_value  in  VAL_W  value to write, in seconds.
- expired  out  1  one-cycle pulse when the running interval completes.
- busy  out  1  high while an interval is counting.
- one_hz_enable  out  1  one-cycle pulse on each prescaler wrap; free-running.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; expired=0; busy=0; one_hz_enable=0; prescaler=0; remaining=0.
  - t_base/t_ext/t_yel = DEF_*.
  - Reset overrides start_timer and reprogram in the same cycle.
- Prescaler (free-running):
  - Counts 0..TICK_DIV-1, then wraps.
  - one_hz_enable is registered high in the cycle after the count reaches TICK_DIV-1.
  - Cleared to 0 when a start is accepted, so every interval begins on a full-second boundary.
- States: IDLE, COUNT, DONE.
  - IDLE:
    - on start_timer: remaining <= selected value; prescaler <= 0; go to COUNT.
    - busy rises on the edge that samples start_timer.
  - COUNT:
    - each prescaler wrap decrements remaining.
    - on the wrap where remaining==1: go to DONE.
  - DONE:
    - expired=1 for exactly one cycle; busy=0; then go to IDLE.
- Latency: start_timer sampled at edge E with value N → expired high during the cycle beginning at edge E + N*TICK_DIV.
- start_timer during COUNT or DONE:
  - restarts the timer with the newly selected value;
  - any pending expired is suppressed, so no pulse is issued for the aborted interval.
- Selected value of 0:
  - loaded as 1, so expired still arrives after one second;
  - busy is never stuck.
- Reprogram:
  - On reprogram, time_value is written to the selected register at that edge.
  - time_value==0 is stored as 1.
  - sel==11 restores all three defaults.
  - A running interval is unaffected; the new value applies from the next start_timer.
- Same-edge start_timer and reprogram: the start loads the OLD parameter value; the write takes effect afterwards.
- Arithmetic:
  - remaining is VAL_W bits, loaded from the stored value, decrement only, no wrap.
  - Prescaler is $clog2(TICK_DIV) bits.

Decomposition:
- Package traffic_timing_pkg:
  - interval encodings INT_BASE=2'b00, INT_EXT=2'b01, INT_YEL=2'b10;
  - restore code SEL_DEFAULTS=2'b11;
  - timer state enum {IDLE, COUNT, DONE}.
- Sub-module one_hz_prescaler:
  - parameter TICK_DIV;
  - ports clk, reset, clear, tick.
- interval_timer holds the parameter registers and the state machine.

Test Plan (TICK_DIV=4, defaults 6/3/2):
- Reset low one edge, then release → expired=0, busy=0; a t_base start gives expired exactly 24 cycles after the start edge.
- requesting_interval=10, start_timer pulse → busy for 8 cycles, expired 1 cycle at start+8, then IDLE; =11 behaves as t_base (24 cycles).
- reprogram sel=01, value=5, then start t_ext → expired at start+20; reprogram sel=11, then start t_ext → expired at start+12.
- Start t_base, reprogram t_base=2 at cycle 5 → expired still at start+24; next t_base start → expired at start+8.
- Start t_base, then start_timer again with t_yel at cycle 10 → no pulse at the original start+24; expired at second start+8.
- reprogram time_value=0 on t_yel, then start t_yel → expired at start+4; reset low at cycle 2 of a running interval → busy=0, no expired pulse, t_yel back to 2.

Source files
------------

// File: rtl/traffic_timing_pkg.sv
// rtl/traffic_timing_pkg.sv - shared encodings and state type for the traffic light interval timer
package traffic_timing_pkg;

   localparam logic [1:0] INT_BASE     = 2'b00;
   localparam logic [1:0] INT_EXT      = 2'b01;
   localparam logic [1:0] INT_YEL      = 2'b10;
   localparam logic [1:0] SEL_DEFAULTS = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } timer_state_t;

   // The unused request code 11 falls back to the base interval.
   function automatic logic [1:0] canon_interval(input logic [1:0] sel);
      return (sel == SEL_DEFAULTS) ? INT_BASE : sel;
   endfunction

endpackage

// File: rtl/one_hz_prescaler.sv
// rtl/one_hz_prescaler.sv - free-running divide-by-TICK_DIV counter with synchronous clear
module one_hz_prescaler #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   // Combinational: high in the last count of each second, so the wrap edge can act on it.
   assign tick = (count == LAST);

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable interval timer and timing-parameter store
module interval_timer
   import traffic_timing_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int VAL_W    = 4,
   parameter int DEF_BASE = 6,
   parameter int DEF_EXT  = 3,
   parameter int DEF_YEL  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_timer,
   input  logic [1:0]       requesting_interval,
   input  logic             reprogram,
   input  logic [1:0]       time_param_sel,
   input  logic [VAL_W-1:0] time_value,
   output logic             expired,
   output logic             busy,
   output logic             one_hz_enable
);

   localparam logic [VAL_W-1:0] DEF_BASE_V = VAL_W'(DEF_BASE);
   localparam logic [VAL_W-1:0] DEF_EXT_V  = VAL_W'(DEF_EXT);
   localparam logic [VAL_W-1:0] DEF_YEL_V  = VAL_W'(DEF_YEL);

   // A zero interval would leave the counter with nothing to count down.
   function automatic logic [VAL_W-1:0] at_least_one(input logic [VAL_W-1:0] v);
      return (v == '0) ? VAL_W'(1) : v;
   endfunction

   logic [VAL_W-1:0] t_base;
   logic [VAL_W-1:0] t_ext;
   logic [VAL_W-1:0] t_yel;
   logic [VAL_W-1:0] sel_value;
   logic [VAL_W-1:0] remaining;
   logic [VAL_W-1:0] remaining_next;
   timer_state_t     state;
   timer_state_t     state_next;
   logic             tick;

   one_hz_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .reset(reset),
      .clear(start_timer),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         t_base <= DEF_BASE_V;
         t_ext  <= DEF_EXT_V;
         t_yel  <= DEF_YEL_V;
      end else if (reprogram) begin
         case (time_param_sel)
            INT_BASE: t_base <= at_least_one(time_value);
            INT_EXT:  t_ext  <= at_least_one(time_value);
            INT_YEL:  t_yel  <= at_least_one(time_value);
            default: begin
               t_base <= DEF_BASE_V;
               t_ext  <= DEF_EXT_V;
               t_yel  <= DEF_YEL_V;
            end
         endcase
      end
   end

   always_comb begin
      sel_value = t_base;
      case (canon_interval(requesting_interval))
         INT_EXT: sel_value = t_ext;
         INT_YEL: sel_value = t_yel;
         default: sel_value = t_base;
      endcase
   end

   // A start in any state reloads the count, which also drops a pulse that was due on this edge.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      if (start_timer) begin
         state_next     = COUNT;
         remaining_next = at_least_one(sel_value);
      end else begin
         case (state)
            COUNT: begin
               if (tick) begin
                  remaining_next = (remaining == '0) ? '0 : remaining - VAL_W'(1);
                  if (remaining <= VAL_W'(1)) begin
                     state_next = DONE;
                  end
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         remaining     <= '0;
         one_hz_enable <= 1'b0;
      end else begin
         state         <= state_next;
         remaining     <= remaining_next;
         one_hz_enable <= tick && !start_timer;
      end
   end

   assign busy    = (state == COUNT);
   assign expired = (state == DONE);

endmodule
